// File: rtl/decrypt_pkg.sv
// Shared constants for the decrypt datapath.
//   BYTE_W        : width of one pipeline byte
//   DEPTH_DEF     : default output-buffer depth (entries)
//   AF_MARGIN_DEF : default free-entry margin for almost_full
//   PIPE_LAT      : decrypt pipeline latency (bytes in flight once feeding stops)
package decrypt_pkg;
    localparam int BYTE_W        = 8;
    localparam int DEPTH_DEF     = 16;
    localparam int AF_MARGIN_DEF = 4;
    localparam int PIPE_LAT      = 3;
endpackage

// File: rtl/decrypt_fifo_mem.sv
// Byte storage for the output buffer: one write port, combinational read.
//   clk, rst : clock and asynchronous active-low reset (array cleared to 0)
//   we       : write enable; wdata is stored at waddr on the rising edge
//   raddr    : read index; rdata follows it combinationally
module decrypt_fifo_mem
    import decrypt_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IW-1:0]     waddr,
    input  logic [BYTE_W-1:0] wdata,
    input  logic [IW-1:0]     raddr,
    output logic [BYTE_W-1:0] rdata
);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [BYTE_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Clearing the array on reset makes the head read back as 0 right after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/decrypt_out_fifo.sv
// Output buffer behind the decrypt pipeline. Captures every valid byte and
// re-issues them in order on a first-word-fall-through valid/ready stream.
//   clk, rst            : clock, asynchronous active-low reset
//   in_v, in_data       : byte strobe/data from the pipeline (no backpressure)
//   flush               : synchronous clear of contents, flags and counter
//   out_valid/ready/data: consumer stream
//   level               : stored entries
//   almost_full         : level >= DEPTH-AF_MARGIN (registered)
//   overflow            : sticky, a byte was dropped while full
//   byte_cnt            : accepted bytes, wraps
module decrypt_out_fifo
    import decrypt_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int AF_MARGIN = AF_MARGIN_DEF,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_v,
    input  logic [BYTE_W-1:0]        in_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full,
    output logic                     overflow,
    output logic [CNT_W-1:0]         byte_cnt
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - AF_MARGIN);

    if (AF_MARGIN < PIPE_LAT) begin : g_bad_margin
        $error("AF_MARGIN must cover the decrypt pipeline latency");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 4");
    end

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    level_q, level_d;
    logic             af_q, af_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic empty, full, pop, push, drop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    // Same index with opposite wrap bit means the writer is a full lap ahead.
    assign full  = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) && (wr_ptr_q[IW] != rd_ptr_q[IW]);
    assign pop   = !empty && out_ready;
    // A pop frees the head slot this cycle, so a full buffer can still take a byte.
    assign push  = in_v && !flush && (!full || pop);
    assign drop  = in_v && !flush && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
            cnt_d    = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                cnt_d    = cnt_q + CNT_W'(1);
            end
            if (drop) begin
                ovf_d = 1'b1;
            end
            case ({push, pop})
                2'b10:   level_d = level_q + PW'(1);
                2'b01:   level_d = level_q - PW'(1);
                default: level_d = level_q;
            endcase
        end
        // Derived from the next level so the flag lines up with level.
        af_d = (level_d >= AF_LEVEL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    decrypt_fifo_mem #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (wr_ptr_q[IW-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr_q[IW-1:0]),
        .rdata (out_data)
    );

    assign out_valid   = !empty;
    assign level       = level_q;
    assign almost_full = af_q;
    assign overflow    = ovf_q;
    assign byte_cnt    = cnt_q;

endmodule

// File: tb/tb_decrypt_out_fifo.sv
module tb_decrypt_out_fifo;

    localparam int DEPTH = 16;
    localparam int AF_TH = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_v = 1'b0;
    logic [7:0]  in_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [4:0]  level;
    logic        almost_full;
    logic        overflow;
    logic [15:0] byte_cnt;

    decrypt_out_fifo dut (
        .clk         (clk),
        .rst         (rst),
        .in_v        (in_v),
        .in_data     (in_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .level       (level),
        .almost_full (almost_full),
        .overflow    (overflow),
        .byte_cnt    (byte_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: queue of stored bytes, sticky drop flag, accepted count.
    logic [7:0] mq[$];
    bit         m_ovf = 0;
    int         m_cnt = 0;

    logic [7:0] last_pop_data;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       rdy;
        logic       vld_e;
        logic [7:0] data_e;
        int         lvl_e;
        int         cnt_e;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 0;
        m_cnt = 0;
    endtask

    task automatic check_state();
        chk("out_valid", int'(out_valid), int'(mq.size() != 0));
        if (mq.size() != 0) chk("out_data", int'(out_data), int'(mq[0]));
        chk("level", int'(level), mq.size());
        chk("almost_full", int'(almost_full), int'(mq.size() >= AF_TH));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("byte_cnt", int'(byte_cnt), m_cnt);
    endtask

    // One clock: drive at the falling edge, check the model, advance the model.
    task automatic tick(input logic v, input logic [7:0] d, input logic rdy, input logic fl);
        bit pop, full;
        @(negedge clk);
        in_v = v; in_data = d; out_ready = rdy; flush = fl;
        check_state();
        if (out_valid && rdy) last_pop_data = out_data;
        pop  = (mq.size() != 0) && rdy;
        full = (mq.size() == DEPTH);
        if (fl) begin
            model_reset();
        end else begin
            if (v && full && !pop) m_ovf = 1;
            if (pop) void'(mq.pop_front());
            if (v && (!full || pop)) begin
                mq.push_back(d);
                m_cnt = (m_cnt + 1) % 65536;
            end
        end
        @(posedge clk);
    endtask

    int maxlvl;

    initial begin
        tbl[0] = '{1'b1, 8'h41, 1'b0, 1'b1, 8'h41, 1, 1};
        tbl[1] = '{1'b1, 8'h42, 1'b0, 1'b1, 8'h41, 2, 2};
        tbl[2] = '{1'b1, 8'h43, 1'b0, 1'b1, 8'h41, 3, 3};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 3, 3};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h42, 2, 3};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h43, 1, 3};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 3};

        // Reset state
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_almost_full", int'(almost_full), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_byte_cnt", int'(byte_cnt), 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // Basic order
        for (int i = 0; i < 7; i++) begin
            tick(tbl[i].v, tbl[i].d, tbl[i].rdy, 1'b0);
            #1;
            chk("tbl_valid", int'(out_valid), int'(tbl[i].vld_e));
            if (tbl[i].vld_e) chk("tbl_data", int'(out_data), int'(tbl[i].data_e));
            chk("tbl_level", int'(level), tbl[i].lvl_e);
            chk("tbl_cnt", int'(byte_cnt), tbl[i].cnt_e);
        end

        // Fill, almost_full, full drop
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) tick(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        #1 chk("af_at_12", int'(almost_full), 1);
        for (int i = 12; i < 16; i++) tick(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        #1 chk("level_full", int'(level), 16);
        tick(1'b1, 8'h99, 1'b0, 1'b0);
        #1;
        chk("drop_overflow", int'(overflow), 1);
        chk("drop_cnt", int'(byte_cnt), 16);
        chk("drop_head", int'(out_data), 8'hA0);

        // Full with simultaneous push and pop
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) tick(1'b1, 8'(i), 1'b0, 1'b0);
        tick(1'b1, 8'h55, 1'b1, 1'b0);
        #1;
        chk("pp_level", int'(level), 16);
        chk("pp_overflow", int'(overflow), 0);
        for (int k = 1; k <= 16; k++) tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pp_16th_read", int'(last_pop_data), 8'h55);

        // Wrap-around streaming
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        maxlvl = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 8'(i), 1'b1, 1'b0);
            #1 if (int'(level) > maxlvl) maxlvl = int'(level);
        end
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("wrap_maxlvl", maxlvl, 1);
        chk("wrap_cnt", int'(byte_cnt), 40);

        // Flush with coincident byte
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) tick(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        tick(1'b1, 8'hEE, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) tick(1'b0, 8'h00, 1'b1, 1'b0);
        #1;
        chk("pre_flush_level", int'(level), 5);
        chk("pre_flush_ovf", int'(overflow), 1);
        tick(1'b1, 8'h77, 1'b1, 1'b1);
        #1;
        chk("flush_level", int'(level), 0);
        chk("flush_valid", int'(out_valid), 0);
        chk("flush_ovf", int'(overflow), 0);
        chk("flush_cnt", int'(byte_cnt), 0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        #1 chk("flush_no_77", int'(out_valid), 0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 7; i++) tick(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        in_v = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_data", int'(out_data), 0);
        chk("arst_level", int'(level), 0);
        chk("arst_af", int'(almost_full), 0);
        chk("arst_ovf", int'(overflow), 0);
        chk("arst_cnt", int'(byte_cnt), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        tick(1'b1, 8'h10, 1'b0, 1'b0);
        #1;
        chk("arst_head_valid", int'(out_valid), 1);
        chk("arst_head_data", int'(out_data), 8'h10);

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            tick(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 39) == 0));
        end
        tick(1'b0, 8'h00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decrypt_out_fifo.md
Name: decrypt_out_fifo

Overview:
- Output buffer directly downstream of the decrypt pipeline.
- Captures every byte the pipeline presents (valid strobe plus data) and re-issues the bytes in order on a valid/ready stream toward the consumer.
- The pipeline has no backpressure, so the block raises almost_full early enough for the controller to stop feeding the pipeline before bytes are lost.
- Any byte that arrives while the buffer is full is dropped and flagged by a sticky overflow bit.

Parameters:
- DEPTH, 16: number of byte entries; must be a power of 2 and at least 4.
- AF_MARGIN, 4: number of free entries at which almost_full asserts; must be at least the decrypt pipeline latency (in-flight bytes).
- CNT_W, 16: width of the accepted-byte counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_v  in  1  input byte valid; driven by the pipeline v output.
- in_data  in  8  input byte; driven by the pipeline dout output.
- flush  in  1  synchronous clear of buffer contents, flags and counter.
- out_valid  out  1  head entry is available.
- out_ready  in  1  consumer accepts the head entry this cycle.
- out_data  out  8  head entry; held stable while out_valid=1 and out_ready=0.
- level  out  $clog2(DEPTH)+1  current number of stored entries.
- almost_full  out  1  asserted when level >= DEPTH-AF_MARGIN.
- overflow  out  1  sticky; set when a byte is dropped because the buffer is full.
- byte_cnt  out  CNT_W  number of bytes accepted; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=0, asynchronous): pointers=0, level=0, out_valid=0, out_data=0, almost_full=0, overflow=0, byte_cnt=0.
- Storage: register array indexed by write and read pointers. Each pointer is $clog2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
  - empty when pointers are equal.
  - full when the index bits are equal and the MSBs differ.
- Output timing: first-word fall-through. out_data = mem[rd_idx]; out_valid = !empty.
  - A byte written at edge N is visible with out_valid=1 in the cycle after edge N.
  - There is no same-cycle bypass from in_data to out_data.
- pop = out_valid && out_ready. On pop, rd_ptr increments.
- push = in_v && !flush && (!full || pop).
  - On push: the byte is stored at wr_idx, wr_ptr increments, byte_cnt increments.
  - Full with a simultaneous pop: push is accepted and level is unchanged.
- Drop condition: in_v && !flush && full && !pop.
  - Byte is discarded; overflow <= 1; byte_cnt is unchanged.
- level: +1 on push only, -1 on pop only, unchanged when both occur or neither occurs.
- almost_full: registered, recomputed from the next level value, so it is valid in the same cycle as the level it describes.
- overflow: cleared only by reset or flush.
- flush: has priority over everything.
  - Next state: pointers=0, level=0, overflow=0, byte_cnt=0; out_valid=0 the following cycle.
  - A coincident in_v byte is discarded and does not set overflow.
  - A coincident out_ready has no effect beyond the clear.
- Pointer wrap: index bits wrap modulo DEPTH and the MSB toggles; no special case at wrap.
- byte_cnt: wraps from 2^CNT_W-1 to 0 with no flag.
- Reset asserted mid-stream: all state cleared immediately; buffered bytes are lost.

Decomposition:
- Shared package decrypt_pkg:
  - BYTE_W = 8.
  - Default DEPTH and AF_MARGIN constants.
  - Pipeline latency constant PIPE_LAT; an elaboration check requires AF_MARGIN >= PIPE_LAT.
- Optional sub-module decrypt_fifo_mem: storage array with write-enable and combinational read. The top level keeps pointers, flags and counter.
- No FSM beyond the pointer/flag logic.

Test Plan:
- Basic order: with out_ready=0, push 0x41,0x42,0x43 on consecutive cycles -> level=3, out_data=0x41 held stable; then raise out_ready -> 0x41,0x42,0x43 on three cycles, then out_valid=0, byte_cnt=3.
- Full / almost_full (DEPTH=16, AF_MARGIN=4):
  - Push 12 -> almost_full=1.
  - Push 4 more -> level=16.
  - Push 0x99 with out_ready=0 -> dropped, overflow=1, byte_cnt=16, head still the first byte.
- Full with simultaneous push and pop: at level=16, in_v=1 with 0x55 and out_ready=1 -> level stays 16, overflow stays 0, and 0x55 appears as the 16th byte read.
- Wrap-around: stream 40 bytes 0x00..0x27 with out_ready=1 throughout -> output sequence identical, level never exceeds 1, byte_cnt=40.
- Flush: with 5 entries and overflow=1, assert flush together with in_v (0x77) -> next cycle level=0, out_valid=0, overflow=0, byte_cnt=0; 0x77 never appears.
- Async reset: drop rst between clock edges with 7 entries stored -> all outputs 0 immediately; after release, the first push 0x10 appears as the head.
